// File: rtl/mtm_alu_pkg.sv
// Shared definitions for the ALU serial-link receive path.
//   op_t          supported ALU opcodes (CMD byte bits [6:4])
//   rx_state_t    packet deserializer FSM states
//   PKT_DATA/CMD  values of the packet type bit
//   crc4          one-bit step of the CRC-4 (x^4+x+1) used to protect a frame
//   op_supported  true when a 3-bit opcode is one the ALU core executes
package mtm_alu_pkg;

   typedef enum logic [2:0] {
      OP_ADD = 3'b000,
      OP_AND = 3'b001,
      OP_OR  = 3'b100,
      OP_SUB = 3'b101
   } op_t;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_TYPE,
      ST_PAYLOAD,
      ST_STOP,
      ST_HUNT
   } rx_state_t;

   localparam logic PKT_DATA = 1'b0;
   localparam logic PKT_CMD  = 1'b1;

   localparam logic [3:0] CRC4_POLY = 4'h3;

   // Serial CRC step, data fed MSB first.
   function automatic logic [3:0] crc4(input logic [3:0] crc, input logic din);
      logic fb;
      fb = crc[3] ^ din;
      return {crc[2:0], 1'b0} ^ (fb ? CRC4_POLY : 4'h0);
   endfunction

   function automatic logic op_supported(input logic [2:0] op);
      case (op)
         OP_ADD, OP_AND, OP_OR, OP_SUB: return 1'b1;
         default:                       return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/mtm_alu_rx_packet.sv
// Packet deserializer for the ALU serial link. Recognises one 11-bit packet
// (start 0, type, 8 payload bits MSB first, stop 1) at a time.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   sin          serial input, idles high
//   pkt_valid    one-cycle strobe: good stop bit seen, pkt_type/pkt_byte valid
//   pkt_type     latched type bit (PKT_DATA / PKT_CMD)
//   pkt_byte     latched payload byte
//   frame_err    one-cycle strobe: stop bit was 0
//   start        start bit seen while idle
//   idle         FSM is waiting for a start bit
//
// state      | meaning
// -----------+-----------------------------------------------
// ST_IDLE    | line idle, waiting for a start bit (sin=0)
// ST_TYPE    | sampling the type bit
// ST_PAYLOAD | shifting in 8 payload bits
// ST_STOP    | sampling the stop bit, commit or flag error
// ST_HUNT    | after a bad stop bit, wait for the line to go high
module mtm_alu_rx_packet
   import mtm_alu_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       sin,
   output logic       pkt_valid,
   output logic       pkt_type,
   output logic [7:0] pkt_byte,
   output logic       frame_err,
   output logic       start,
   output logic       idle
);

   rx_state_t  state_q, state_d;
   logic [2:0] bit_cnt_q;
   logic [7:0] byte_q;
   logic       type_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= ST_IDLE;
      else        state_q <= state_d;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bit_cnt_q <= 3'd0;
         byte_q    <= 8'h00;
         type_q    <= 1'b0;
      end else begin
         if (state_q == ST_TYPE) begin
            type_q    <= sin;
            bit_cnt_q <= 3'd0;
         end
         if (state_q == ST_PAYLOAD) begin
            byte_q    <= {byte_q[6:0], sin};
            bit_cnt_q <= bit_cnt_q + 3'd1;
         end
      end
   end

   always_comb begin
      state_d   = state_q;
      pkt_valid = 1'b0;
      frame_err = 1'b0;
      start     = 1'b0;
      idle      = 1'b0;
      case (state_q)
         ST_IDLE: begin
            idle = 1'b1;
            if (!sin) begin
               start   = 1'b1;
               state_d = ST_TYPE;
            end
         end
         ST_TYPE:    state_d = ST_PAYLOAD;
         ST_PAYLOAD: if (bit_cnt_q == 3'd7) state_d = ST_STOP;
         ST_STOP: begin
            if (sin) begin
               pkt_valid = 1'b1;
               state_d   = ST_IDLE;
            end else begin
               frame_err = 1'b1;
               state_d   = ST_HUNT;
            end
         end
         ST_HUNT:    if (sin) state_d = ST_IDLE;
         default:    state_d = ST_IDLE;
      endcase
   end

   assign pkt_type = type_q;
   assign pkt_byte = byte_q;

endmodule

// File: rtl/mtm_alu_rx_frame.sv
// Receive front-end for the ALU serial link: assembles B, A and CMD packets
// into a frame, checks it and holds it in a one-entry valid/ready buffer.
// Optional CRC-4 frame check is built when MTM_ALU_RX_CRC_EN is defined;
// otherwise err_crc_o is 0 and ctl_o[3:0] passes through unchecked.
// Parameters: DATA_W operand width (multiple of 8), TIMEOUT idle cycles
// allowed between packets of a frame (0 = no timeout).
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   sin                 serial input, idles high
//   out_valid/out_ready frame buffer handshake
//   a_o, b_o, ctl_o     operands and raw CMD byte; op_o = ctl_o[6:4]
//   err_data_o/crc/op   frame error flags, at most one set
//   frame_err_o         pulse: bad stop bit or inter-packet timeout
//   ovf_o               pulse: completed frame dropped, buffer full
module mtm_alu_rx_frame
   import mtm_alu_pkg::*;
#(
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 64
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              sin,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] a_o,
   output logic [DATA_W-1:0] b_o,
   output logic [7:0]        ctl_o,
   output logic [2:0]        op_o,
   output logic              err_data_o,
   output logic              err_crc_o,
   output logic              err_op_o,
   output logic              frame_err_o,
   output logic              ovf_o
);

   localparam int NB     = DATA_W / 8;
   localparam int NBYTES = 2 * NB;
   localparam int CW     = $clog2(NBYTES + 2);

   logic       pkt_valid, pkt_type, pkt_frame_err, pkt_start, pkt_idle;
   logic [7:0] pkt_byte;

   mtm_alu_rx_packet u_packet (
      .clk       (clk),
      .rst_n     (rst_n),
      .sin       (sin),
      .pkt_valid (pkt_valid),
      .pkt_type  (pkt_type),
      .pkt_byte  (pkt_byte),
      .frame_err (pkt_frame_err),
      .start     (pkt_start),
      .idle      (pkt_idle)
   );

   logic [CW-1:0]       cnt_q;
   logic [2*DATA_W-1:0] sh_q;
   logic                data_commit, cmd_commit, timeout_hit, discard;

   assign data_commit = pkt_valid && (pkt_type == PKT_DATA);
   assign cmd_commit  = pkt_valid && (pkt_type == PKT_CMD);
   assign discard     = pkt_frame_err || timeout_hit;

   // Inter-packet timer: counts idle cycles only while a frame is partly received.
   generate
      if (TIMEOUT > 0) begin : g_timeout
         localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
         logic [TW-1:0] idle_q;
         logic          run;

         assign run         = pkt_idle && !pkt_start && (cnt_q != '0);
         assign timeout_hit = run && (idle_q == TW'(TIMEOUT - 1));

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)                idle_q <= '0;
            else if (!run || timeout_hit) idle_q <= '0;
            else                       idle_q <= idle_q + TW'(1);
         end
      end else begin : g_no_timeout
         assign timeout_hit = 1'b0;
      end
   endgenerate

   // Frame assembly. Once past 2*NB bytes the counter sticks so an overlong
   // frame still reads as a count error, while the shift register keeps the
   // most recent 2*NB bytes.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
         sh_q  <= '0;
      end else if (discard || cmd_commit) begin
         cnt_q <= '0;
         sh_q  <= '0;
      end else if (data_commit) begin
         sh_q <= {sh_q[2*DATA_W-9:0], pkt_byte};
         if (cnt_q != CW'(NBYTES + 1)) cnt_q <= cnt_q + CW'(1);
      end
   end

   logic [2:0] cmd_op;
   logic       crc_bad, err_data_d, err_crc_d, err_op_d;

   assign cmd_op = pkt_byte[6:4];

`ifdef MTM_ALU_RX_CRC_EN
   logic [3:0] crc_calc;
   always_comb begin
      crc_calc = 4'h0;
      for (int i = 2*DATA_W - 1; i >= 0; i--) crc_calc = crc4(crc_calc, sh_q[i]);
      crc_calc = crc4(crc_calc, 1'b1);
      for (int i = 2; i >= 0; i--) crc_calc = crc4(crc_calc, cmd_op[i]);
   end
   assign crc_bad = (crc_calc != pkt_byte[3:0]);
`else
   assign crc_bad = 1'b0;
`endif

   assign err_data_d = (cnt_q != CW'(NBYTES));
   assign err_crc_d  = !err_data_d && crc_bad;
   assign err_op_d   = !err_data_d && !crc_bad && !op_supported(cmd_op);

   // Output buffer. A drain and a commit in the same cycle reload it directly.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid   <= 1'b0;
         a_o         <= '0;
         b_o         <= '0;
         ctl_o       <= 8'h00;
         err_data_o  <= 1'b0;
         err_crc_o   <= 1'b0;
         err_op_o    <= 1'b0;
         frame_err_o <= 1'b0;
         ovf_o       <= 1'b0;
      end else begin
         frame_err_o <= discard;
         ovf_o       <= 1'b0;
         if (cmd_commit) begin
            if (!out_valid || out_ready) begin
               out_valid  <= 1'b1;
               a_o        <= sh_q[DATA_W-1:0];
               b_o        <= sh_q[2*DATA_W-1:DATA_W];
               ctl_o      <= pkt_byte;
               err_data_o <= err_data_d;
               err_crc_o  <= err_crc_d;
               err_op_o   <= err_op_d;
            end else begin
               ovf_o <= 1'b1;
            end
         end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
         end
      end
   end

   assign op_o = ctl_o[6:4];

endmodule
